// File: rtl/rr_arb8_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arb8_pkg                                               |
// | Brief    : Shared constants and FSM encoding for the rr_arb8 arbiter |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package rr_arb8_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage : rr_arb8_pkg
`default_nettype wire

// File: rtl/decode3_8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : decode3_8                                                 |
// | Brief    : 3-to-8 binary to one-hot decoder                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module decode3_8 (
  input  logic [2:0] din,
  output logic [7:0] dout
);

  // Pure combinational decode: exactly one output bit set for every input code.
  always_comb begin
    dout = 8'b0000_0001 << din;
  end

endmodule : decode3_8
`default_nettype wire

// File: rtl/rr_arb8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arb8                                                   |
// | Brief    : 8-way round-robin arbiter with hold timeout and one-hot   |
// |            grant decode                                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic              done,
  output logic [NREQ-1:0]   gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld,
  output logic              timeout
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;

  logic [IDX_W-1:0]     w_winner;
  logic                 w_owner_req;
  logic                 w_limit;
  logic                 w_release;
  logic [NREQ-1:0]      w_dec;

  // Scan starting at the pointer and wrapping modulo 8; the first set bit wins.
  // Adding the loop offset to the pointer in IDX_W bits performs the
  // rotate / find-first / un-rotate in one step via natural wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = p + IDX_W'(i);
      if (!found && r[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_winner    = rr_pick(req, ptr_q);
  assign w_owner_req = req[idx_q];
  assign w_limit     = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign w_release   = done || !w_owner_req || w_limit;

  // Next-state logic: grant on any request in IDLE, release in BUSY on
  // done, owner drop, or hold limit. Timeout flags a counter-only release.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = w_winner;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (w_release) begin
          state_d   = IDLE;
          ptr_d     = idx_q + IDX_W'(1);
          timeout_d = !done && w_owner_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  decode3_8 u_decode (
    .din  (idx_q),
    .dout (w_dec)
  );

  // The valid flag is simply the BUSY state; the decode is masked by it.
  always_comb begin
    gnt_vld = (state_q == BUSY);
    gnt     = w_dec & {NREQ{gnt_vld}};
    gnt_idx = idx_q;
    timeout = timeout_q;
  end

endmodule : rr_arb8
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rr_arb8                                                |
// | Brief    : Directed table-driven bench for rr_arb8                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_rr_arb8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  rr_arb8 #(
    .HOLD_MAX (16),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [7:0] q, input logic d,
                              input logic [7:0] g, input logic [2:0] i,
                              input logic v, input logic t);
    vec_t e;
    e.rst = r; e.req = q; e.done = d; e.gnt = g; e.idx = i; e.vld = v; e.to = t;
    vecs.push_back(e);
  endfunction

  task automatic step(input logic r, input logic [7:0] q, input logic d);
    rst  = r;
    req  = q;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] g, input logic [2:0] i,
                     input logic v, input logic t);
    checks++;
    if (gnt !== g || gnt_idx !== i || gnt_vld !== v || timeout !== t) begin
      errors++;
      $display("FAIL %s: got gnt=%h idx=%0d vld=%b to=%b, want gnt=%h idx=%0d vld=%b to=%b",
               name, gnt, gnt_idx, gnt_vld, timeout, g, i, v, t);
    end
  endtask

  initial begin
    int n;
    int bound;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset with all requesting, then first grant goes to idx 0.
    add(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    add(1, 8'hFF, 0, 8'h00, 3'd0, 0, 0);
    add(0, 8'hFF, 0, 8'h01, 3'd0, 1, 0);
    // Owner drops request: release, ptr -> 1.
    add(0, 8'h10, 0, 8'h00, 3'd0, 0, 0);
    // Single request: one-cycle latency, then done releases.
    add(0, 8'h10, 0, 8'h10, 3'd4, 1, 0);
    add(0, 8'h10, 1, 8'h00, 3'd4, 0, 0);
    // done in IDLE does nothing; gnt_idx keeps last owner.
    add(0, 8'h00, 1, 8'h00, 3'd4, 0, 0);
    add(1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    // Fairness: all requesting, done every third cycle, wrap 7 -> 0.
    for (int k = 0; k < 8; k++) begin
      add(0, 8'hFF, 0, 8'(1 << k), 3'(k), 1, 0);
      add(0, 8'hFF, 0, 8'(1 << k), 3'(k), 1, 0);
      add(0, 8'hFF, 1, 8'h00,      3'(k), 0, 0);
    end
    add(0, 8'hFF, 0, 8'h01, 3'd0, 1, 0);
    // Non-owner request bits changing during BUSY are ignored.
    add(0, 8'h01, 0, 8'h01, 3'd0, 1, 0);
    add(0, 8'h0F, 0, 8'h01, 3'd0, 1, 0);
    add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    // done coincides with the hold limit: normal release, no timeout.
    add(0, 8'h04, 0, 8'h04, 3'd2, 1, 0);
    for (int k = 0; k < 15; k++) add(0, 8'h04, 0, 8'h04, 3'd2, 1, 0);
    add(0, 8'h04, 1, 8'h00, 3'd2, 0, 0);
    // Steer ptr to 7, then wrap scan with req=81.
    add(0, 8'h40, 0, 8'h40, 3'd6, 1, 0);
    add(0, 8'h00, 0, 8'h00, 3'd6, 0, 0);
    add(0, 8'h81, 0, 8'h80, 3'd7, 1, 0);
    add(0, 8'h01, 0, 8'h00, 3'd7, 0, 0);
    add(0, 8'h01, 0, 8'h01, 3'd0, 1, 0);
    // Single requester re-granted after one idle cycle.
    add(0, 8'h01, 1, 8'h00, 3'd0, 0, 0);
    add(0, 8'h01, 0, 8'h01, 3'd0, 1, 0);
    // Reset mid-grant clears grant and pointer.
    add(0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    add(0, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    add(1, 8'h20, 0, 8'h00, 3'd0, 0, 0);
    add(0, 8'h21, 0, 8'h01, 3'd0, 1, 0);

    foreach (vecs[v]) begin
      step(vecs[v].rst, vecs[v].req, vecs[v].done);
      chk($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].idx, vecs[v].vld, vecs[v].to);
    end

    // Hold timeout: grant lasts exactly 16 cycles, then a one-cycle pulse.
    step(0, 8'h00, 0);
    chk("to_pre_idle", 8'h00, 3'd0, 0, 0);
    step(0, 8'h04, 0);
    chk("to_grant", 8'h04, 3'd2, 1, 0);
    n = 1;
    bound = 0;
    while (gnt == 8'h04 && bound < 40) begin
      step(0, 8'h04, 0);
      if (gnt == 8'h04) n++;
      bound++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL to_hold_len: got %0d cycles, want 16", n);
    end
    chk("to_pulse", 8'h00, 3'd2, 0, 1);
    step(0, 8'h04, 0);
    chk("to_regrant", 8'h04, 3'd2, 1, 0);
    step(0, 8'h00, 0);
    chk("to_clear", 8'h00, 3'd2, 0, 0);

    // Reset wins over simultaneous request and done.
    step(0, 8'h08, 0);
    chk("pre_rst_grant", 8'h08, 3'd3, 1, 0);
    step(1, 8'hFF, 1);
    chk("rst_prio", 8'h00, 3'd0, 0, 0);
    step(0, 8'hFF, 0);
    chk("post_rst_grant", 8'h01, 3'd0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_arb8
`default_nettype wire

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
- Round-robin arbiter that shares one 3-to-8-decoded resource between 8 requesters.
- Picks one requester, registers its 3-bit index, and drives a one-hot grant through the team's decode3_8 decoder.
- Holds the grant until the owner releases it or a hold timeout fires.
- Sits in front of any shared resource selected by a one-hot enable bus.

Parameters:
- HOLD_MAX, 16: maximum cycles one grant may be held before forced release; legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i.
- done  input  1  current owner releases the grant; ignored when gnt_vld=0.
- gnt  output  8  one-hot grant; all zeros when gnt_vld=0.
- gnt_idx  output  3  index of current owner; holds last value when idle.
- gnt_vld  output  1  a grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Behaviour:
- Reset values, applied on the rst edge and valid the following cycle:
  - state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0.
  - Internal: ptr=0, hold_cnt=0.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... ptr+7, with indices mod 8.
  - On that edge: gnt_idx <= winner, gnt_vld <= 1, hold_cnt <= 0, state <= BUSY.
  - Latency: req sampled in cycle t gives gnt visible in cycle t+1.
  - If req == 0, stay in IDLE; outputs unchanged.
- BUSY:
  - gnt, gnt_idx and gnt_vld are stable; hold_cnt increments each cycle.
  - The release condition is (done=1) OR (req[gnt_idx]=0) OR (hold_cnt == HOLD_MAX-1).
  - On release:
    - gnt_vld <= 0, state <= IDLE.
    - ptr <= gnt_idx+1, with 7 wrapping to 0.
    - timeout <= 1 only if the release is caused solely by the counter, i.e. done=0 and req[gnt_idx]=1.
  - Otherwise, stay in BUSY.
- Every release forces at least one IDLE cycle: there are no back-to-back grants, and gnt is 0 for ≥1 cycle between owners.
- A grant is held for at most HOLD_MAX cycles (gnt_vld=1 for cycles t+1 .. t+HOLD_MAX).
- timeout is a single-cycle pulse, coincident with the first IDLE cycle, then cleared.
- gnt = decode3_8(gnt_idx) ANDed bitwise with {8{gnt_vld}}; the combinational decode adds no extra latency.
- Boundary cases:
  - ptr=7, so the scan wraps 7→0→1…
  - A single requester that re-requests is re-granted after one idle cycle.
  - done asserted in IDLE has no effect.
  - Other bits of req changing during BUSY have no effect.
  - done and the counter limit coincide: normal release, timeout=0.
  - rst asserted mid-BUSY: next cycle gnt=0, ptr=0, timeout=0.
  - rst has priority over every other input.
- Fairness: with all 8 requesting continuously, grant order is 0,1,…,7,0,…

Decomposition:
- Shared package holds:
  - NREQ=8.
  - IDX_W=3.
  - The state encoding, IDLE=1'b0 and BUSY=1'b1.
- Sub-module: reuse the existing decode3_8 (din=gnt_idx, dout→raw one-hot) for the grant decode.
- The priority scan (rotate by ptr, find first set, un-rotate) stays inline as a combinational function in rr_arb8.

Test Plan:
- Reset: apply rst=1 for 2 cycles with req=8'hFF → gnt=0, gnt_vld=0, timeout=0; first grant after release goes to idx 0 (gnt=8'h01).
- Single request: req=8'h10 at cycle t → cycle t+1 gnt=8'h10, gnt_idx=4; done=1 for one cycle → next cycle gnt=0, timeout=0.
- Fairness/wrap: req=8'hFF held, done pulsed every 3rd cycle → grants in order 8'h01,8'h02,…,8'h80,8'h01, each separated by one zero cycle.
- Timeout: HOLD_MAX=16, req=8'h04 held, done=0 → gnt=8'h04 for exactly 16 cycles, then gnt=0 with timeout=1 for one cycle, then re-grant 8'h04.
- Requester drop and pointer wrap:
  - With ptr=7 and req=8'h81, the winner is idx 7 (gnt=8'h80).
  - Deasserting req[7] releases the grant.
  - After one idle cycle the grant goes to idx 0 (gnt=8'h01).
- Reset mid-grant: rst=1 while gnt=8'h20 → next cycle gnt=0; after rst deasserts, req=8'h21 is granted to idx 0 first.
